// File: rtl/arb_requester_if.sv
// Handshake bundle for arb_requester: upstream push, arbiter req/grant, downstream beats and timeout.
// master = the requester block, slave = the surrounding logic that feeds and drains it.
interface arb_requester_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              req;
    logic              grant;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              timeout;

    modport master (
        input  in_valid, in_data, in_last, grant, out_ready,
        output in_ready, req, out_valid, out_data, out_last, timeout
    );

    modport slave (
        output in_valid, in_data, in_last, grant, out_ready,
        input  in_ready, req, out_valid, out_data, out_last, timeout
    );
endinterface

// File: rtl/arb_requester.sv
// Packet FIFO + requester for a fixed-priority arbiter; first beat 3 cycles after the last word is pushed (grant held).
// in_ready = FIFO not full; out_valid gated by grant. Grant-wait timeout pulse built only under ARB_REQUESTER_TIMEOUT_EN.

module arb_requester_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset: pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
        end
    end

    assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
endmodule

module arb_requester #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    arb_requester_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic [CW-1:0]     pkt_cnt_q, pkt_cnt_d;
    logic              fifo_full, fifo_empty;
    logic              push, pop, out_vld;
    logic              push_last, pop_last;
    logic [DATA_W:0]   head_word;

    arb_requester_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat ({bus.in_last, bus.in_data}),
        .pop      (pop),
        .pop_dat  (head_word),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign push      = bus.in_valid && !fifo_full;
    assign out_vld   = (state_q == S_XFER) && bus.grant && !fifo_empty;
    assign pop       = out_vld && bus.out_ready;
    assign push_last = push && bus.in_last;
    assign pop_last  = pop && head_word[DATA_W];

    assign bus.in_ready  = !fifo_full;
    assign bus.out_valid = out_vld;
    assign bus.out_data  = head_word[DATA_W-1:0];
    assign bus.out_last  = head_word[DATA_W];
    assign bus.req       = req_q;

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (push_last && !pop_last) begin
            pkt_cnt_d = pkt_cnt_q + CW'(1);
        end else if (pop_last && !push_last) begin
            pkt_cnt_d = pkt_cnt_q - CW'(1);
        end
    end

    // Full also triggers a request so packets longer than the FIFO can drain.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if ((pkt_cnt_q != '0) || fifo_full) state_d = S_REQ;
            S_REQ:  if (bus.grant) state_d = S_XFER;
            S_XFER: if (pop_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        req_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

`ifdef ARB_REQUESTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          to_hit;

    // Counter holds completed waiting cycles; the pulse lands on the TIMEOUT-th one.
    always_comb begin
        to_hit   = (state_q == S_REQ) && !bus.grant && (to_cnt_q == TW'(TIMEOUT - 1));
        to_cnt_d = '0;
        if ((state_q == S_REQ) && !bus.grant && !to_hit) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign bus.timeout = to_hit;
`else
    // Constant 0 for every legal TIMEOUT; an illegal TIMEOUT of 0 shows up as a stuck pulse.
    assign bus.timeout = (TIMEOUT == 0);
`endif
endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: cycle table for the basic and grant-toggle flows, hand sequences for
// FIFO-full long packet, simultaneous push/pop, grant-wait timeout and reset during transfer.
module tb_arb_requester;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arb_requester_if #(.DATA_W(DW)) bus();

    arb_requester #(
        .DATA_W  (DW),
        .DEPTH   (8),
        .TIMEOUT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic          iv;
        logic [DW-1:0] id;
        logic          il;
        logic          gnt;
        logic          ordy;
        logic          e_ir;
        logic          e_req;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic          e_ol;
    } vec_t;

    vec_t vt[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] id, input logic il,
                         input logic gnt, input logic ordy);
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.in_last   = il;
        bus.grant     = gnt;
        bus.out_ready = ordy;
    endtask

    task automatic add(input logic iv, input logic [DW-1:0] id, input logic il, input logic gnt,
                       input logic ordy, input logic e_ir, input logic e_req, input logic e_ov,
                       input logic [DW-1:0] e_od, input logic e_ol);
        vec_t v;
        v.iv = iv; v.id = id; v.il = il; v.gnt = gnt; v.ordy = ordy;
        v.e_ir = e_ir; v.e_req = e_req; v.e_ov = e_ov; v.e_od = e_od; v.e_ol = e_ol;
        vt.push_back(v);
    endtask

    task automatic beat(input string nm, input logic [DW-1:0] od, input logic ol);
        chk({nm, ".out_valid"}, bus.out_valid, 1);
        chk({nm, ".out_data"}, bus.out_data, od);
        chk({nm, ".out_last"}, bus.out_last, ol);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic exp_to;

        //   iv  data     il gnt ordy | ir req ov  data    ol
        // 3-word packet with grant held high
        add(1, 32'hA1, 0, 1, 1,   1, 0, 0, 32'h0,  0);
        add(1, 32'hA2, 0, 1, 1,   1, 0, 0, 32'h0,  0);
        add(1, 32'hA3, 1, 1, 1,   1, 0, 0, 32'h0,  0);
        add(0, 32'h0,  0, 1, 1,   1, 0, 0, 32'h0,  0);
        add(0, 32'h0,  0, 1, 1,   1, 1, 0, 32'h0,  0);
        add(0, 32'h0,  0, 1, 1,   1, 1, 1, 32'hA1, 0);
        add(0, 32'h0,  0, 1, 1,   1, 1, 1, 32'hA2, 0);
        add(0, 32'h0,  0, 1, 1,   1, 1, 1, 32'hA3, 1);
        add(0, 32'h0,  0, 1, 1,   1, 0, 0, 32'h0,  0);
        // two packets queued, grant drops for one cycle mid-packet
        add(1, 32'hB1, 0, 0, 1,   1, 0, 0, 32'h0,  0);
        add(1, 32'hB2, 0, 0, 1,   1, 0, 0, 32'h0,  0);
        add(1, 32'hB3, 1, 0, 1,   1, 0, 0, 32'h0,  0);
        add(1, 32'hC1, 0, 0, 1,   1, 0, 0, 32'h0,  0);
        add(1, 32'hC2, 1, 0, 1,   1, 1, 0, 32'h0,  0);
        add(0, 32'h0,  0, 1, 1,   1, 1, 0, 32'h0,  0);
        add(0, 32'h0,  0, 1, 1,   1, 1, 1, 32'hB1, 0);
        add(0, 32'h0,  0, 0, 1,   1, 1, 0, 32'h0,  0);
        add(0, 32'h0,  0, 1, 1,   1, 1, 1, 32'hB2, 0);
        add(0, 32'h0,  0, 1, 1,   1, 1, 1, 32'hB3, 1);
        add(0, 32'h0,  0, 1, 1,   1, 0, 0, 32'h0,  0);
        add(0, 32'h0,  0, 1, 1,   1, 1, 0, 32'h0,  0);
        add(0, 32'h0,  0, 1, 1,   1, 1, 1, 32'hC1, 0);
        add(0, 32'h0,  0, 1, 1,   1, 1, 1, 32'hC2, 1);
        add(0, 32'h0,  0, 0, 1,   1, 0, 0, 32'h0,  0);

        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("rst.in_ready", bus.in_ready, 1);
        chk("rst.req", bus.req, 0);
        chk("rst.out_valid", bus.out_valid, 0);
        chk("rst.timeout", bus.timeout, 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vt[i]) begin
            drive(vt[i].iv, vt[i].id, vt[i].il, vt[i].gnt, vt[i].ordy);
            #1;
            chk($sformatf("vec%0d.in_ready", i), bus.in_ready, vt[i].e_ir);
            chk($sformatf("vec%0d.req", i), bus.req, vt[i].e_req);
            chk($sformatf("vec%0d.out_valid", i), bus.out_valid, vt[i].e_ov);
            chk($sformatf("vec%0d.timeout", i), bus.timeout, 0);
            if (vt[i].e_ov) begin
                chk($sformatf("vec%0d.out_data", i), bus.out_data, vt[i].e_od);
                chk($sformatf("vec%0d.out_last", i), bus.out_last, vt[i].e_ol);
            end
            @(negedge clk);
        end

        // Long packet: 8 words fill the FIFO, full forces a request, 10th word ends it.
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'hD0 + i, 0, 0, 1);
            #1;
            chk($sformatf("fill%0d.in_ready", i), bus.in_ready, 1);
            chk($sformatf("fill%0d.req", i), bus.req, 0);
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 1);
        #1;
        chk("full.in_ready", bus.in_ready, 0);
        chk("full.req_idle", bus.req, 0);
        @(negedge clk);
        drive(1, 32'hD8, 0, 1, 1);
        #1;
        chk("full_req.req", bus.req, 1);
        chk("full_req.in_ready", bus.in_ready, 0);
        chk("full_req.out_valid", bus.out_valid, 0);
        @(negedge clk);
        #1;
        beat("long0", 32'hD0, 0);
        chk("long0.in_ready", bus.in_ready, 0);
        @(negedge clk);
        #1;
        chk("pp1.in_ready", bus.in_ready, 1);
        beat("long1", 32'hD1, 0);
        @(negedge clk);
        drive(1, 32'hD9, 1, 1, 1);
        #1;
        chk("pp2.in_ready", bus.in_ready, 1);
        beat("long2", 32'hD2, 0);
        @(negedge clk);
        drive(0, 0, 0, 1, 1);
        for (int k = 3; k <= 9; k++) begin
            #1;
            beat($sformatf("long%0d", k), 32'hD0 + k, (k == 9));
            chk($sformatf("long%0d.in_ready", k), bus.in_ready, 1);
            @(negedge clk);
        end
        #1;
        chk("long_done.req", bus.req, 0);
        chk("long_done.out_valid", bus.out_valid, 0);
        @(negedge clk);
        #1;
        chk("long_idle.req", bus.req, 0);
        @(negedge clk);

        // Grant held low: timeout pulses on the 4th and 8th waiting cycle when enabled.
        drive(1, 32'hE0, 1, 0, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 1);
        #1;
        chk("to_idle.req", bus.req, 0);
        @(negedge clk);
        for (int w = 1; w <= 10; w++) begin
            #1;
`ifdef ARB_REQUESTER_TIMEOUT_EN
            exp_to = (w == 4) || (w == 8);
`else
            exp_to = 1'b0;
`endif
            chk($sformatf("wait%0d.timeout", w), bus.timeout, exp_to);
            chk($sformatf("wait%0d.req", w), bus.req, 1);
            chk($sformatf("wait%0d.out_valid", w), bus.out_valid, 0);
            @(negedge clk);
        end
        drive(0, 0, 0, 1, 1);
        #1;
        chk("to_grant.out_valid", bus.out_valid, 0);
        chk("to_grant.timeout", bus.timeout, 0);
        @(negedge clk);
        #1;
        beat("to_beat", 32'hE0, 1);
        @(negedge clk);
        #1;
        chk("to_done.req", bus.req, 0);

        // Reset mid-transfer with two words still queued.
        drive(1, 32'hF0, 0, 0, 1);
        @(negedge clk);
        drive(1, 32'hF1, 0, 0, 1);
        @(negedge clk);
        drive(1, 32'hF2, 1, 0, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 1);
        @(negedge clk);
        drive(0, 0, 0, 1, 1);
        @(negedge clk);
        #1;
        beat("pre_rst", 32'hF0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst.req", bus.req, 0);
        chk("mid_rst.out_valid", bus.out_valid, 0);
        chk("mid_rst.in_ready", bus.in_ready, 1);
        chk("mid_rst.timeout", bus.timeout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("post_rst%0d.out_valid", c), bus.out_valid, 0);
            chk($sformatf("post_rst%0d.req", c), bus.req, 0);
            @(negedge clk);
        end
        drive(1, 32'h60, 1, 1, 1);
        @(negedge clk);
        drive(0, 0, 0, 1, 1);
        #1;
        chk("new_pkt.req_idle", bus.req, 0);
        @(negedge clk);
        #1;
        chk("new_pkt.req", bus.req, 1);
        chk("new_pkt.out_valid_req", bus.out_valid, 0);
        @(negedge clk);
        #1;
        beat("new_pkt", 32'h60, 1);
        @(negedge clk);
        #1;
        chk("new_pkt_done.req", bus.req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/arb_requester.md
ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter DATA_W, default 32, width of payload word.
REQ-002 Parameter DEPTH, default 8, FIFO entries, power of two, >=2.
REQ-003 Parameter TIMEOUT, default 255, grant-wait limit in cycles, >=1.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  upstream word valid.
REQ-007 in_ready  output  1  FIFO can accept a word.
REQ-008 in_data  input  DATA_W  upstream payload.
REQ-009 in_last  input  1  word ends a packet.
REQ-010 req  output  1  request bit toward the fixed-priority arbiter.
REQ-011 grant  input  1  grant bit from the arbiter for this requester; may drop at any cycle.
REQ-012 out_valid  output  1  granted beat valid.
REQ-013 out_ready  input  1  downstream accepts beat.
REQ-014 out_data  output  DATA_W  beat payload.
REQ-015 out_last  output  1  beat ends a packet.
REQ-016 timeout  output  1  one-cycle pulse, grant-wait limit hit.

Function
REQ-017 FIFO stores {in_last,in_data}; push on in_valid&in_ready; pop on out_valid&out_ready.
REQ-018 in_ready = FIFO not full, independent of same-cycle pop.
REQ-019 Simultaneous push and pop in one cycle: both happen; occupancy unchanged.
REQ-020 pkt_cnt counts complete packets held: +1 on push with in_last, -1 on pop with out_last, unchanged when both occur.
REQ-021 FSM states IDLE, REQ, XFER; req SHALL be registered and equal 1 exactly when state is REQ or XFER.
REQ-022 IDLE->REQ when pkt_cnt>0 or FIFO full (full covers packets longer than DEPTH).
REQ-023 REQ->XFER on rising edge where grant=1; req stays high.
REQ-024 out_valid = (state==XFER) & grant & FIFO not empty; out_data/out_last = FIFO head.
REQ-025 grant low in XFER: out_valid=0, state and req held, transfer resumes when grant returns.
REQ-026 FIFO empty in XFER before out_last (long packet): out_valid=0, remain in XFER until data arrives.
REQ-027 XFER->IDLE on pop with out_last; req low the following cycle; at most one packet per grant tenure.
REQ-028 From IDLE, next REQ entry occurs one cycle after return to IDLE if REQ-022 holds (req drops for >=1 cycle between packets).
REQ-029 grant while state is IDLE is ignored.

Reset
REQ-030 rst_n low: state=IDLE, FIFO empty, pkt_cnt=0, timeout counter=0, immediately.
REQ-031 Output values during/after reset: req=0, out_valid=0, timeout=0, in_ready=1; out_data/out_last don't-care.
REQ-032 Reset mid-packet discards all FIFO content; no partial packet resumes.

Configuration
REQ-033 Macro ARB_REQUESTER_TIMEOUT_EN defined: counter increments each cycle in REQ with grant=0, clears on leaving REQ; on reaching TIMEOUT, timeout pulses 1 cycle, counter restarts at 0, req stays high.
REQ-034 Macro undefined: no counter logic; timeout tied 0; all other behaviour identical.

Verification
REQ-035 Push 3-word packet A1..A3, grant tied 1, out_ready 1 -> req rises, beats A1,A2,A3 on consecutive cycles, out_last on A3, req low next cycle.
REQ-036 Two packets queued, grant toggles 1,0,1 mid-first-packet -> out_valid gaps exactly in grant=0 cycles, no beat lost/duplicated, req drops 1 cycle between packets.
REQ-037 DEPTH=8, push 8 words without in_last -> in_ready=0, req asserted on full; draining frees space, packet completes with 10th word in_last.
REQ-038 Push and pop same cycle with FIFO at DEPTH-1 -> occupancy stays DEPTH-1, in_ready stays 1, pkt_cnt correct.
REQ-039 TIMEOUT_EN, TIMEOUT=4, grant held 0 for 10 cycles -> timeout pulses at 4th and 8th waiting cycles, req stays 1; macro off -> timeout never 1.
REQ-040 rst_n asserted during XFER with 2 words pending -> req=0, out_valid=0 same cycle, in_ready=1; after release no beat emitted until new packet pushed.
